scene_sequencer: RTL and testbench

- Frame-level controller that sequences the scene byte stream into the display datapath.
- On START it fetches the 5-byte global header: object count, X centre, Y centre, angle, zoom.
- It then fetches each object descriptor of OBJ_BYTES bytes and issues it downstream over a valid/ready handshake, one object at a time.
- Sits between the scene byte source (memory/FIFO reader) and the object renderer; it replaces ad-hoc STATUS/NEXT/FINISH signalling with explicit handshakes.

---
 rtl/scene_seq_pkg.sv | 27 ++
 rtl/obj_byte_packer.sv | 44 ++++
 rtl/scene_sequencer.sv | 137 +++++++++++++
 tb/tb_scene_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/scene_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : scene_seq_pkg
// Purpose  : Shared state encoding and header layout for the scene sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package scene_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_FETCH = 3'd2,
        ST_ISSUE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam int HDR_BYTES = 5;

    // Byte positions within the global frame header
    localparam logic [2:0] HDR_CNT  = 3'd0;
    localparam logic [2:0] HDR_X    = 3'd1;
    localparam logic [2:0] HDR_Y    = 3'd2;
    localparam logic [2:0] HDR_ANG  = 3'd3;
    localparam logic [2:0] HDR_ZOOM = 3'd4;

endpackage
`default_nettype wire

// File: rtl/obj_byte_packer.sv
`default_nettype none
// ============================================================================
// Module   : obj_byte_packer
// Purpose  : Assembles OBJ_BYTES stream bytes into one packed descriptor.
// Revision : 1.0 - initial release
// ============================================================================
module obj_byte_packer #(
    parameter int OBJ_BYTES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr_i,
    input  logic                   load_i,
    input  logic [7:0]             byte_i,
    output logic [8*OBJ_BYTES-1:0] data_o,
    output logic                   full_o
);

    localparam int IDX_W = (OBJ_BYTES > 1) ? $clog2(OBJ_BYTES) : 1;
    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(OBJ_BYTES - 1);

    logic [IDX_W-1:0]       idx_q;
    logic [8*OBJ_BYTES-1:0] data_q;

    // full_o marks the load that completes the descriptor, not a held level
    assign full_o = load_i && (idx_q == c_LAST_IDX);
    assign data_o = data_q;

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            idx_q  <= '0;
            data_q <= '0;
        end else if (load_i) begin
            for (int k = 0; k < OBJ_BYTES; k++) begin
                if (idx_q == IDX_W'(k)) begin
                    data_q[8*k +: 8] <= byte_i;
                end
            end
            idx_q <= full_o ? '0 : idx_q + IDX_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/scene_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : scene_sequencer
// Purpose  : Fetches the frame header and object descriptors from the scene
//            byte stream and issues each object over a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module scene_sequencer
    import scene_seq_pkg::*;
#(
    parameter int OBJ_BYTES = 4,
    parameter int CNT_W     = 8
) (
    input  logic                   ACLK,
    input  logic                   ARESET,
    input  logic                   START,
    input  logic                   ABORT,
    output logic                   BYTE_REQ,
    input  logic                   BYTE_VALID,
    input  logic [7:0]             BYTE_DATA,
    output logic [7:0]             X_CENTER,
    output logic [7:0]             Y_CENTER,
    output logic [7:0]             ANGLE,
    output logic [7:0]             ZOOM,
    output logic                   HDR_VALID,
    output logic [8*OBJ_BYTES-1:0] OBJ_DATA,
    output logic [CNT_W-1:0]       OBJ_INDEX,
    output logic                   OBJ_VALID,
    input  logic                   OBJ_READY,
    output logic                   BUSY,
    output logic                   FRAME_DONE
);

    localparam logic [CNT_W-1:0] c_ONE = CNT_W'(1);

    state_e           state_q, state_d;
    logic [2:0]       hdr_idx_q;
    logic [CNT_W-1:0] remaining_q;
    logic [CNT_W-1:0] obj_index_q;
    logic [7:0]       x_q, y_q, ang_q, zoom_q;
    logic             hdr_valid_q;

    logic w_abort, w_start_go, w_xfer, w_hdr_xfer, w_hdr_last;
    logic w_pack_load, w_pack_full, w_obj_hs;

    assign w_abort     = ABORT && (state_q != ST_IDLE);
    assign w_start_go  = START && !ABORT && (state_q == ST_IDLE);
    // A byte arriving alongside ABORT is dropped rather than consumed
    assign w_xfer      = BYTE_REQ && BYTE_VALID && !ABORT;
    assign w_hdr_xfer  = w_xfer && (state_q == ST_HDR);
    assign w_hdr_last  = w_hdr_xfer && (hdr_idx_q == HDR_ZOOM);
    assign w_pack_load = w_xfer && (state_q == ST_FETCH);
    assign w_obj_hs    = (state_q == ST_ISSUE) && OBJ_READY && !ABORT;

    obj_byte_packer #(
        .OBJ_BYTES (OBJ_BYTES)
    ) u_packer (
        .clk    (ACLK),
        .rst    (ARESET),
        .clr_i  (w_start_go),
        .load_i (w_pack_load),
        .byte_i (BYTE_DATA),
        .data_o (OBJ_DATA),
        .full_o (w_pack_full)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (w_start_go) state_d = ST_HDR;
            ST_HDR:   if (w_hdr_last) state_d = (remaining_q == '0) ? ST_DONE : ST_FETCH;
            ST_FETCH: if (w_pack_full) state_d = ST_ISSUE;
            ST_ISSUE: if (w_obj_hs) state_d = (remaining_q == c_ONE) ? ST_DONE : ST_FETCH;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (w_abort) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q     <= ST_IDLE;
            hdr_idx_q   <= '0;
            remaining_q <= '0;
            obj_index_q <= '0;
            x_q         <= '0;
            y_q         <= '0;
            ang_q       <= '0;
            zoom_q      <= '0;
            hdr_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (w_start_go) begin
                hdr_valid_q <= 1'b0;
                hdr_idx_q   <= '0;
                obj_index_q <= '0;
                remaining_q <= '0;
            end
            if (w_abort) begin
                hdr_valid_q <= 1'b0;
            end
            if (w_hdr_xfer) begin
                hdr_idx_q <= hdr_idx_q + 3'd1;
                case (hdr_idx_q)
                    HDR_CNT:  remaining_q <= CNT_W'(BYTE_DATA);
                    HDR_X:    x_q         <= BYTE_DATA;
                    HDR_Y:    y_q         <= BYTE_DATA;
                    HDR_ANG:  ang_q       <= BYTE_DATA;
                    HDR_ZOOM: begin
                        zoom_q      <= BYTE_DATA;
                        hdr_valid_q <= 1'b1;
                    end
                    default: ;
                endcase
            end
            if (w_obj_hs) begin
                remaining_q <= remaining_q - c_ONE;
                obj_index_q <= obj_index_q + c_ONE;
            end
        end
    end

    assign BYTE_REQ   = (state_q == ST_HDR) || (state_q == ST_FETCH);
    assign BUSY       = (state_q != ST_IDLE);
    assign OBJ_VALID  = (state_q == ST_ISSUE);
    assign FRAME_DONE = (state_q == ST_DONE) && !ABORT;
    assign OBJ_INDEX  = obj_index_q;
    assign HDR_VALID  = hdr_valid_q;
    assign X_CENTER   = x_q;
    assign Y_CENTER   = y_q;
    assign ANGLE      = ang_q;
    assign ZOOM       = zoom_q;

endmodule
`default_nettype wire

// File: tb/tb_scene_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_scene_sequencer
// Purpose  : Self-checking bench for scene_sequencer (directed table plus
//            randomized frames against a byte-stream reference model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_scene_sequencer;

    localparam int OB = 4;
    localparam int CW = 8;
    localparam int HB = 5;

    logic            ACLK = 1'b0;
    logic            ARESET, START, ABORT, BYTE_REQ, BYTE_VALID;
    logic [7:0]      BYTE_DATA, X_CENTER, Y_CENTER, ANGLE, ZOOM;
    logic            HDR_VALID, OBJ_VALID, OBJ_READY, BUSY, FRAME_DONE;
    logic [8*OB-1:0] OBJ_DATA;
    logic [CW-1:0]   OBJ_INDEX;

    scene_sequencer #(.OBJ_BYTES(OB), .CNT_W(CW)) dut (
        .ACLK(ACLK), .ARESET(ARESET), .START(START), .ABORT(ABORT),
        .BYTE_REQ(BYTE_REQ), .BYTE_VALID(BYTE_VALID), .BYTE_DATA(BYTE_DATA),
        .X_CENTER(X_CENTER), .Y_CENTER(Y_CENTER), .ANGLE(ANGLE), .ZOOM(ZOOM),
        .HDR_VALID(HDR_VALID), .OBJ_DATA(OBJ_DATA), .OBJ_INDEX(OBJ_INDEX),
        .OBJ_VALID(OBJ_VALID), .OBJ_READY(OBJ_READY), .BUSY(BUSY),
        .FRAME_DONE(FRAME_DONE)
    );

    always #5 ACLK = ~ACLK;

    int total = 0;
    int bad   = 0;

    logic [7:0]      src_q[$];
    logic [8*OB-1:0] got_q[$];
    int              first_valid_cyc;

    typedef struct {
        logic [39:0] hdr;
        logic [63:0] objs;
        int          bv_mode;
        int          rdy_mode;
        logic [31:0] exp0;
        logic [31:0] exp1;
        int          exp_hs;
        int          exp_done_cyc;
        int          exp_first_valid;
    } vec_t;

    vec_t vecs[3];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic make_frame(input int cnt);
        src_q.delete();
        src_q.push_back(8'(cnt));
        for (int i = 0; i < 4 + cnt * OB + 3; i++) src_q.push_back(8'($urandom));
    endtask

    // Plays the byte source and renderer for one frame, predicting every
    // object from the raw byte stream.
    task automatic run_frame(input int bv_mode, input int rdy_mode, input int abort_ptr,
                             input bit poke_start, output int done_cyc);
        int cnt, ptr, hs, cyc, limit;
        bit fin, stalled;
        logic [8*OB-1:0] exp_obj[$];
        logic [8*OB-1:0] e, prev_data;
        logic [CW-1:0]   prev_idx;
        cnt = int'(src_q[0]);
        for (int i = 0; i < cnt; i++) begin
            e = '0;
            for (int k = 0; k < OB; k++) e[8*k +: 8] = src_q[HB + i*OB + k];
            exp_obj.push_back(e);
        end
        ptr = 0; hs = 0; cyc = 0; fin = 0; stalled = 0; done_cyc = -1;
        prev_data = '0; prev_idx = '0;
        first_valid_cyc = -1;
        got_q.delete();
        limit = 100 + cnt * 20;
        while (!fin && cyc < limit) begin
            @(posedge ACLK); #1;
            START = (cyc == 0) || (poke_start && (cyc % 7 == 3));
            ABORT = (abort_ptr >= 0) && (ptr == abort_ptr);
            case (bv_mode)
                0:       BYTE_VALID = 1'b1;
                1:       BYTE_VALID = (cyc % 2 == 0);
                default: BYTE_VALID = 1'($urandom_range(0, 1));
            endcase
            BYTE_DATA = (BYTE_VALID && ptr < src_q.size()) ? src_q[ptr] : 8'($urandom);
            case (rdy_mode)
                0:       OBJ_READY = 1'b1;
                1:       OBJ_READY = (cyc % 6 == 5);
                default: OBJ_READY = 1'($urandom_range(0, 1));
            endcase
            @(negedge ACLK);
            if (ABORT) begin
                check("abort_same_cycle_done", 64'(FRAME_DONE), 64'(0));
                @(posedge ACLK); #1;
                ABORT = 0; START = 0; BYTE_VALID = 0; OBJ_READY = 0;
                @(negedge ACLK);
                check("abort_busy", 64'(BUSY), 64'(0));
                check("abort_hdr_valid", 64'(HDR_VALID), 64'(0));
                check("abort_obj_valid", 64'(OBJ_VALID), 64'(0));
                check("abort_frame_done", 64'(FRAME_DONE), 64'(0));
                check("abort_x_kept", 64'(X_CENTER), 64'(src_q[1]));
                check("abort_zoom_kept", 64'(ZOOM), 64'(src_q[4]));
                return;
            end
            if (BYTE_REQ && BYTE_VALID) ptr++;
            if (OBJ_VALID) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (hs >= cnt) check("obj_valid_extra", 64'(1), 64'(0));
                if (stalled) begin
                    check("stall_data_stable", 64'(OBJ_DATA), 64'(prev_data));
                    check("stall_index_stable", 64'(OBJ_INDEX), 64'(prev_idx));
                end
                if (OBJ_READY) begin
                    if (hs < cnt) check("obj_data", 64'(OBJ_DATA), 64'(exp_obj[hs]));
                    check("obj_index", 64'(OBJ_INDEX), 64'(hs));
                    got_q.push_back(OBJ_DATA);
                    hs++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    prev_data = OBJ_DATA;
                    prev_idx = OBJ_INDEX;
                end
            end else begin
                stalled = 0;
            end
            if (FRAME_DONE) begin
                fin = 1;
                done_cyc = cyc;
            end
            cyc++;
        end
        if (!fin) begin
            check("frame_timeout", 64'(1), 64'(0));
            return;
        end
        check("handshake_count", 64'(hs), 64'(cnt));
        check("bytes_consumed", 64'(ptr), 64'(HB + cnt * OB));
        check("x_center", 64'(X_CENTER), 64'(src_q[1]));
        check("y_center", 64'(Y_CENTER), 64'(src_q[2]));
        check("angle", 64'(ANGLE), 64'(src_q[3]));
        check("zoom", 64'(ZOOM), 64'(src_q[4]));
        check("hdr_valid_at_done", 64'(HDR_VALID), 64'(1));
        if (bv_mode == 0 && rdy_mode == 0)
            check("done_latency", 64'(done_cyc), 64'(6 + cnt * (OB + 1)));
        @(posedge ACLK); #1;
        START = 0; ABORT = 0; BYTE_VALID = 0; OBJ_READY = 0;
        @(negedge ACLK);
        check("post_done_busy", 64'(BUSY), 64'(0));
        check("done_single_pulse", 64'(FRAME_DONE), 64'(0));
        check("hdr_valid_held", 64'(HDR_VALID), 64'(1));
    endtask

    initial begin
        int dc, p;
        ARESET = 1; START = 0; ABORT = 0; BYTE_VALID = 0; BYTE_DATA = 0; OBJ_READY = 0;

        vecs[0] = '{40'h40_30_20_10_00, 64'h0, 0, 0, 32'h0, 32'h0, 0, 6, -1};
        vecs[1] = '{40'h40_30_20_10_02, 64'h44332211_DDCCBBAA, 0, 0,
                    32'hDDCCBBAA, 32'h44332211, 2, 16, 10};
        vecs[2] = '{40'h40_30_20_10_02, 64'h44332211_DDCCBBAA, 1, 1,
                    32'hDDCCBBAA, 32'h44332211, 2, -1, -1};

        repeat (3) @(posedge ACLK);
        #1 ARESET = 0;
        @(negedge ACLK);
        check("reset_outputs_a", 64'({BYTE_REQ, X_CENTER, Y_CENTER, ANGLE, ZOOM, HDR_VALID}), 64'(0));
        check("reset_outputs_b", 64'({OBJ_DATA, OBJ_INDEX, OBJ_VALID, BUSY, FRAME_DONE}), 64'(0));

        for (int v = 0; v < 3; v++) begin
            src_q.delete();
            for (int k = 0; k < 5; k++) src_q.push_back(vecs[v].hdr[8*k +: 8]);
            for (int k = 0; k < 8; k++) src_q.push_back(vecs[v].objs[8*k +: 8]);
            run_frame(vecs[v].bv_mode, vecs[v].rdy_mode, -1, 1'b0, dc);
            check("vec_handshakes", 64'(got_q.size()), 64'(vecs[v].exp_hs));
            if (vecs[v].exp_hs > 0) begin
                check("vec_obj0", 64'(got_q[0]), 64'(vecs[v].exp0));
                check("vec_obj1", 64'(got_q[1]), 64'(vecs[v].exp1));
            end
            if (vecs[v].exp_done_cyc >= 0)
                check("vec_done_cycle", 64'(dc), 64'(vecs[v].exp_done_cyc));
            if (vecs[v].exp_first_valid >= 0)
                check("vec_first_valid", 64'(first_valid_cyc), 64'(vecs[v].exp_first_valid));
        end

        // Reset mid-FETCH
        make_frame(3);
        p = 0;
        BYTE_VALID = 1; OBJ_READY = 0;
        for (int c = 0; c < 9; c++) begin
            @(posedge ACLK); #1;
            START = (c == 0);
            BYTE_DATA = src_q[p];
            @(negedge ACLK);
            if (BYTE_REQ) p++;
        end
        check("midfetch_byte_req", 64'(BYTE_REQ), 64'(1));
        check("midfetch_bytes", 64'(p), 64'(HB + 3));
        @(posedge ACLK); #1 ARESET = 1;
        @(posedge ACLK); #1 ARESET = 0; BYTE_VALID = 0;
        @(negedge ACLK);
        check("midfetch_reset_a", 64'({BYTE_REQ, X_CENTER, Y_CENTER, ANGLE, ZOOM, HDR_VALID}), 64'(0));
        check("midfetch_reset_b", 64'({OBJ_DATA, OBJ_INDEX, OBJ_VALID, BUSY, FRAME_DONE}), 64'(0));

        // ABORT during the second object's FETCH, then a clean restart
        make_frame(3);
        run_frame(1, 0, HB + OB + 1, 1'b0, dc);
        check("abort_objs_before", 64'(got_q.size()), 64'(1));
        make_frame(2);
        run_frame(0, 0, -1, 1'b0, dc);

        for (int r = 0; r < 6; r++) begin
            make_frame($urandom_range(0, 6));
            run_frame($urandom_range(0, 2), $urandom_range(0, 2), -1, 1'b0, dc);
        end

        // 255 objects with START poked while busy
        make_frame(255);
        run_frame(0, 2, -1, 1'b1, dc);
        check("cnt255_handshakes", 64'(got_q.size()), 64'(255));
        check("cnt255_last_index", 64'(OBJ_INDEX), 64'(255));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
